// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result, zero/overflow/illegal flags.
// Define ALU_MUL_EN to build the iterative radix-2 signed multiply on opcode 8.
module alu_pipe #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [3:0]              control,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    zero,
  output logic                    overflow,
  output logic                    illegal
);
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_NOR = 4'hC;

  if (WIDTH < 8 || WIDTH > 64 || (2**CNT_W) <= WIDTH) begin : g_bad_params
    $error("alu_pipe: WIDTH must be 8..64 and 2**CNT_W must exceed WIDTH");
  end

  // ADD overflows on like-signed operands, SUB on unlike-signed, when the result sign flips
  function automatic logic signed_ovf(input logic sub, input logic sa, input logic sb,
                                      input logic sr);
    return (sub ? (sa != sb) : (sa == sb)) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] sum, diff, alu_res;
  logic                    add_ovf, sub_ovf, alu_ovf, alu_ill;
  logic                    accept, load_alu, mul_done;
  logic [WIDTH-1:0]        mul_res;

  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    overflow_q, overflow_d, illegal_q, illegal_d;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = signed_ovf(1'b0, a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
  assign sub_ovf = signed_ovf(1'b1, a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
  assign accept  = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (control)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
      OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_NOR: alu_res = ~(a | b);
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'h8;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, mul_term;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_mul, last_iter, mul_busy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_busy  = (state_q == S_MUL);
    in_ready  = !mul_busy && (!out_valid_q || out_ready);
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    mul_done  = mul_busy && last_iter;
    start_mul = accept && (control == OP_MUL);
    load_alu  = accept && (control != OP_MUL);
  end

  // One multiplier bit per cycle; low WIDTH bits of the unsigned sum equal the signed product
  assign mul_term = mplier_q[0] ? mcand_q : '0;
  assign mul_res  = acc_q + mul_term;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_mul) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (mul_busy) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = mul_res;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign load_alu = accept;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  // Output slot: drains on transfer, reloads on the same edge when a new result lands
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    if (load_alu) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      overflow_d  = alu_ovf;
      illegal_d   = alu_ill;
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = $signed(mul_res);
      overflow_d  = 1'b0;
      illegal_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle 48-bit ALU, for use in the processor datapath.
- Registers every result behind a valid/ready interface and reports zero, overflow and illegal-opcode flags.
- Adds an iterative multi-cycle signed multiply.
- Keeps the existing control encoding so decode logic is unchanged.

Parameters:
- WIDTH, 48, operand/result width in bits (legal range 8 to 64).
- CNT_W, 7, multiply iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- control  in  4  opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, C NOR, 8 MUL
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  signed result
- zero  out  1  result equals 0
- overflow  out  1  signed overflow (ADD/SUB only)
- illegal  out  1  opcode not supported

Behaviour:
- Reset (rst=1 at a clk edge) forces these values:
  - state=IDLE, out_valid=0, result=0, zero=1, overflow=0, illegal=0.
  - Multiplier accumulator and counter cleared.
  - Reset wins over every other event, including mid-multiply; the partial multiply is discarded.
- Transfer rules:
  - Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back issue at full rate.
- States:
  - IDLE -> IDLE on an accepted single-cycle opcode.
  - IDLE -> MUL on an accepted opcode 8.
  - MUL -> IDLE when the counter reaches WIDTH-1.
- Single-cycle ops (0, 1, 2, 6, 7, C):
  - Result is registered on the accept edge, so out_valid=1 on the following cycle (latency 1).
- ADD/SUB:
  - Results wrap modulo 2^WIDTH.
  - overflow=1 when the operand signs satisfy the signed-overflow condition and the result sign differs.
- SLT:
  - result=1 if signed a<b, else 0. Computed overflow-safe: (a-b) sign XOR overflow.
- NOR is ~(a|b).
- overflow=0 for every opcode except ADD/SUB.
- MUL:
  - Operands are latched at accept. The block performs a radix-2 shift-add over WIDTH iterations, one bit per cycle.
  - out_valid rises WIDTH+1 cycles after accept.
  - result is the low WIDTH bits of the signed product; the product is truncated with no overflow flag.
  - in_ready=0 throughout the MUL state.
- Illegal opcode: result=0, zero=1, illegal=1, latency 1, handshake otherwise normal.
- zero is derived from the registered result and is valid whenever out_valid=1.
- Output buffering:
  - result and flags stay stable while out_valid && !out_ready.
  - out_valid falls after the transfer unless a new result is loaded on the same edge.
- A multiply completing while the output is still held is not allowed: MUL is only accepted when the output slot is free or draining that cycle, and the slot then remains reserved until completion.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 8 performs the iterative multiply described above.
- Undefined:
  - The MUL state and datapath are absent.
  - Opcode 8 is treated as illegal: result=0, illegal=1, latency 1.
  - in_ready depends only on the output slot.

Test Plan:
- ADD, a=-16, b=16 -> one cycle later result=0, zero=1, overflow=0, illegal=0.
- ADD, a=0x7FFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000, overflow=1. SUB, a=-10, b=-5 -> result=-5, overflow=0.
- SLT, a=0x8000_0000_0000, b=1 -> result=1. SLT, a=3, b=-5 -> result=0. NOR, a=0xAAAA_AAAA_AAAA, b=0x5555_5555_5555 -> result=0, zero=1.
- MUL, a=3, b=-5 (ALU_MUL_EN defined) -> in_ready=0 for 48 cycles, out_valid at cycle 49, result=-15. Without the macro -> illegal=1, result=0 at cycle 1.
- Backpressure: hold out_ready=0 and issue OR a=0, b=0xFFFF_FFFF_FFFF, then AND:
  - Result 0xFFFF_FFFF_FFFF is held stable and in_ready=0.
  - Raise out_ready -> AND accepted in the same cycle, and its result appears next cycle.
- Assert rst at cycle 20 of a MUL -> next cycle out_valid=0, in_ready=1, result=0. A following ADD 1+1 returns 2.
